// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Holds the FSM state encoding, command and writeback-tag constants, and the request entry layout.
// Ports: none (package only).
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_WB   = 2'd3
  } lsu_state_e;

  localparam logic CMD_LOAD  = 1'b0;
  localparam logic CMD_STORE = 1'b1;

  localparam logic [1:0] TAG_RSA = 2'b00;
  localparam logic [1:0] TAG_RSB = 2'b01;
  localparam logic [1:0] TAG_RMW = 2'b10;

  // Request entry layout, MSB first: {cmd, width, tag, rmw, adr[15:0], st_data[15:0]}
  localparam int REQ_W       = 36;
  localparam int ST_DATA_LSB = 0;
  localparam int ADR_LSB     = 16;
  localparam int RMW_BIT     = 32;
  localparam int TAG_BIT     = 33;
  localparam int WIDTH_BIT   = 34;
  localparam int CMD_BIT     = 35;

  typedef struct packed {
    logic        cmd;
    logic        width;
    logic        tag;
    logic        rmw;
    logic [15:0] adr;
    logic [15:0] st_data;
  } req_t;

  // Writeback tag is {rmw, tag}. An RMW result keeps the station bit in bit 0.
  function automatic logic [1:0] wb_tag(input req_t r);
    logic [1:0] t;
    t = r.tag ? TAG_RSB : TAG_RSA;
    if (r.rmw) t = t | TAG_RMW;
    return t;
  endfunction

endpackage

// File: rtl/lsu_req_fifo.sv
// In-order request buffer: DEPTH x WIDTH circular FIFO with a registered full flag.
// Latency: a push is visible at head one cycle later; head is read combinationally from storage.
// Backpressure: a push is dropped while full is set, even if a pop happens at the same edge.
// Ports: clk, a_rst, push/push_dat (write side), pop (read side), full, empty, head.
module lsu_req_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_d;
  logic             full_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = full_q;
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full_q;
  assign do_pop  = pop & ~empty;

  always_comb begin
    count_d = count;
    if (do_push && !do_pop)      count_d = count + CW'(1);
    else if (do_pop && !do_push) count_d = count - CW'(1);
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count  <= count_d;
      full_q <= (count_d == CW'(DEPTH));
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: queues LSU requests and runs each one as one or two byte cycles on an 8-bit bus.
// Latency: a zero-wait byte load accepted at edge E strobes data_wb in the cycle after E+2; words add one cycle.
// Backpressure: lsu_wait (registered FIFO full) refuses requests; mem_rdy low stretches each byte cycle.
// Ports: rq_* request side, lsu_wait, data_out/data_tag/data_wb writeback, mem_* external byte bus.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        a_rst,
  input  logic        rq_start,
  input  logic        rq_cmd,
  input  logic        rq_width,
  input  logic        rq_tag,
  input  logic        rq_rmw,
  input  logic [15:0] rq_adr,
  input  logic [15:0] rq_st_data,
  output logic        lsu_wait,
  output logic [15:0] data_out,
  output logic [1:0]  data_tag,
  output logic        data_wb,
  output logic [15:0] mem_adr,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic        mem_rdy
);

  logic [REQ_W-1:0] push_vec;
  logic [REQ_W-1:0] head_vec;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  req_t             head;

  always_comb begin
    push_vec                        = '0;
    push_vec[CMD_BIT]               = rq_cmd;
    push_vec[WIDTH_BIT]             = rq_width;
    push_vec[TAG_BIT]               = rq_tag;
    push_vec[RMW_BIT]               = rq_rmw;
    push_vec[ADR_LSB +: 16]         = rq_adr;
    push_vec[ST_DATA_LSB +: 16]     = rq_st_data;
  end

  lsu_req_fifo #(.DEPTH(DEPTH), .WIDTH(REQ_W)) u_req_fifo (
    .clk      (clk),
    .a_rst    (a_rst),
    .push     (rq_start),
    .push_dat (push_vec),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head_vec)
  );

  assign lsu_wait = fifo_full;
  assign head     = req_t'(head_vec);

  lsu_state_e  state_q, state_d;
  req_t        wrk_q, wrk_d;
  logic [7:0]  lo_q, lo_d;
  logic        rd_d, wr_d, wb_d, launch;
  logic [15:0] adr_d, out_d;
  logic [7:0]  dout_d;
  logic [1:0]  tag_d;

  always_comb begin
    state_d  = state_q;
    wrk_d    = wrk_q;
    lo_d     = lo_q;
    fifo_pop = 1'b0;
    launch   = 1'b0;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    adr_d    = mem_adr;
    dout_d   = mem_dout;
    wb_d     = 1'b0;
    out_d    = data_out;
    tag_d    = data_tag;

    case (state_q)
      ST_IDLE: launch = ~fifo_empty;

      ST_LO: begin
        rd_d   = (wrk_q.cmd == CMD_LOAD);
        wr_d   = (wrk_q.cmd == CMD_STORE);
        adr_d  = wrk_q.adr;
        dout_d = wrk_q.st_data[7:0];
        if (mem_rdy) begin
          if (wrk_q.cmd == CMD_LOAD) lo_d = mem_din;
          if (wrk_q.width) begin
            // Strobes stay up; the high byte cycle starts straight away.
            state_d = ST_HI;
            adr_d   = wrk_q.adr + 16'd1;
            dout_d  = wrk_q.st_data[15:8];
          end else if (wrk_q.cmd == CMD_LOAD) begin
            rd_d    = 1'b0;
            state_d = ST_WB;
            wb_d    = 1'b1;
            out_d   = {8'h00, mem_din};
            tag_d   = wb_tag(wrk_q);
          end else begin
            wr_d    = 1'b0;
            state_d = ST_IDLE;
            launch  = ~fifo_empty;
          end
        end
      end

      ST_HI: begin
        rd_d   = (wrk_q.cmd == CMD_LOAD);
        wr_d   = (wrk_q.cmd == CMD_STORE);
        adr_d  = wrk_q.adr + 16'd1;
        dout_d = wrk_q.st_data[15:8];
        if (mem_rdy) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          if (wrk_q.cmd == CMD_LOAD) begin
            state_d = ST_WB;
            wb_d    = 1'b1;
            out_d   = {mem_din, lo_q};
            tag_d   = wb_tag(wrk_q);
          end else begin
            state_d = ST_IDLE;
            launch  = ~fifo_empty;
          end
        end
      end

      ST_WB: begin
        state_d = ST_IDLE;
        launch  = ~fifo_empty;
      end

      default: state_d = ST_IDLE;
    endcase

    // Pop on the same edge that retires the previous request so IDLE takes no cycle.
    if (launch) begin
      fifo_pop = 1'b1;
      wrk_d    = head;
      state_d  = ST_LO;
      rd_d     = (head.cmd == CMD_LOAD);
      wr_d     = (head.cmd == CMD_STORE);
      adr_d    = head.adr;
      dout_d   = head.st_data[7:0];
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q  <= ST_IDLE;
      wrk_q    <= '0;
      lo_q     <= '0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      mem_adr  <= '0;
      mem_dout <= '0;
      data_wb  <= 1'b0;
      data_out <= '0;
      data_tag <= '0;
    end else begin
      state_q  <= state_d;
      wrk_q    <= wrk_d;
      lo_q     <= lo_d;
      mem_rd   <= rd_d;
      mem_wr   <= wr_d;
      mem_adr  <= adr_d;
      mem_dout <= dout_d;
      data_wb  <= wb_d;
      data_out <= out_d;
      data_tag <= tag_d;
    end
  end

endmodule
